// File: rtl/ysyx_22040175_dmem_resp_if.sv
// CPU load/store channel between the pipeline (master)
// and a data-memory responder (slave).
interface ysyx_22040175_dmem_resp_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [63:0] req_addr;
   logic [63:0] req_wdata;
   logic [7:0]  req_wmask;
   logic        resp_valid;
   logic        resp_ready;
   logic [63:0] resp_rdata;
   logic        resp_err;

   modport master (
      output req_valid,
      output req_wen,
      output req_addr,
      output req_wdata,
      output req_wmask,
      output resp_ready,
      input  req_ready,
      input  resp_valid,
      input  resp_rdata,
      input  resp_err
   );

   modport slave (
      input  req_valid,
      input  req_wen,
      input  req_addr,
      input  req_wdata,
      input  req_wmask,
      input  resp_ready,
      output req_ready,
      output resp_valid,
      output resp_rdata,
      output resp_err
   );
endinterface

// File: rtl/ysyx_22040175_dmem_resp.sv
// Single-outstanding data memory responder with a fixed
// request-to-response latency and byte-lane stores.
module ysyx_22040175_dmem_resp #(
   parameter logic [63:0] BASE    = 64'h8000_0000,
   parameter int          DEPTH   = 4096,
   parameter int          LATENCY = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   ysyx_22040175_dmem_resp_if.slave   bus
);

   localparam int          IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [63:0] SPAN = 64'(DEPTH) << 3;
   localparam logic [3:0]  LAT4 = 4'(LATENCY);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t      state;
   state_t      state_n;
   logic [3:0]  cnt;
   logic [3:0]  cnt_n;

   logic        wen_q;
   logic [63:0] addr_q;
   logic [63:0] wdata_q;
   logic [7:0]  wmask_q;

   logic [63:0] rdata_q;
   logic        err_q;

   logic [63:0] mem [DEPTH];

   logic        accept;
   logic        enter_resp;
   logic        resp_fire;

   logic        sel_wen;
   logic [63:0] sel_addr;
   logic [63:0] sel_wdata;
   logic [7:0]  sel_wmask;

   logic [63:0] off;
   logic        in_range;
   logic [IW-1:0] idx;
   logic [63:0] cur;
   logic [63:0] merged;

   assign bus.req_ready  = (state == IDLE) && !rst;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.resp_err   = err_q;

   assign accept    = bus.req_valid && bus.req_ready;
   assign resp_fire = (state == RESP) && bus.resp_ready;

   // With zero latency the access completes on the accept edge,
   // so the live bus fields stand in for the captured ones.
   always_comb begin
      sel_wen   = wen_q;
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
      sel_wmask = wmask_q;
      if (state == IDLE) begin
         sel_wen   = bus.req_wen;
         sel_addr  = bus.req_addr;
         sel_wdata = bus.req_wdata;
         sel_wmask = bus.req_wmask;
      end
   end

   assign off      = sel_addr - BASE;
   assign in_range = (sel_addr >= BASE) && (off < SPAN);
   assign idx      = off[IW+2:3];
   assign cur      = mem[idx];

   always_comb begin
      merged = cur;
      for (int i = 0; i < 8; i++) begin
         if (sel_wmask[i]) begin
            merged[8*i +: 8] = sel_wdata[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      enter_resp = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               if (LATENCY == 0) begin
                  state_n    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_n = WAIT;
                  cnt_n   = LAT4;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd1) begin
               state_n    = RESP;
               enter_resp = 1'b1;
               cnt_n      = 4'd0;
            end else begin
               cnt_n = cnt - 4'd1;
            end
         end
         RESP: begin
            if (bus.resp_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         wen_q   <= bus.req_wen;
         addr_q  <= bus.req_addr;
         wdata_q <= bus.req_wdata;
         wmask_q <= bus.req_wmask;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end else if (enter_resp) begin
         rdata_q <= (!sel_wen && in_range) ? cur : 64'd0;
         err_q   <= !in_range;
      end else if (resp_fire) begin
         rdata_q <= 64'd0;
         err_q   <= 1'b0;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (!rst && enter_resp && sel_wen && in_range) begin
         mem[idx] <= merged;
      end
   end

endmodule

// File: doc/ysyx_22040175_dmem_resp.md
YSYX_22040175_DMEM_RESP -- requirements
Module: ysyx_22040175_dmem_resp

Interface
REQ-001 SHALL expose parameters (name, default, meaning), one per line:
- BASE, 64'h8000_0000, first byte address served.
- DEPTH, 4096, number of 64-bit words in storage.
- LATENCY, 2, wait cycles between request accept and response, legal range 0..15.
REQ-002 SHALL expose ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock, rising edge.
- rst, in, 1, reset; synchronous, active-high.
- req_valid, in, 1, CPU request present.
- req_ready, out, 1, responder can accept a request.
- req_wen, in, 1, 1 = store, 0 = load.
- req_addr, in, 64, byte address.
- req_wdata, in, 64, store data, byte lanes aligned to the 8-byte word.
- req_wmask, in, 8, byte-lane write enable; bit i enables wdata[8i+7:8i].
- resp_valid, out, 1, response present.
- resp_ready, in, 1, CPU accepts the response.
- resp_rdata, out, 64, load data: the full aligned word.
- resp_err, out, 1, address outside [BASE, BASE+8*DEPTH).
REQ-003 SHALL be the responder (slave) end of the CPU load/store valid/ready interface; the CPU pipeline is the initiator.

Function
REQ-004 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-005 SHALL drive req_ready=1 only in IDLE; at most one transaction is outstanding.
REQ-006 SHALL accept a request on a clk edge with req_valid&&req_ready, and capture req_wen, addr, wdata and wmask in internal registers.
REQ-007 SHALL, on accept, go to WAIT and load a 4-bit counter with LATENCY when LATENCY>0; when LATENCY=0, go directly to RESP.
REQ-008 SHALL decrement the counter each WAIT cycle and enter RESP on the edge where the counter is 1.
REQ-009 SHALL assert resp_valid on the cycle following accept plus LATENCY cycles (LATENCY=0 gives resp_valid in the cycle after accept).
REQ-010 SHALL form the word index as (addr-BASE)>>3, ignoring addr[2:0]; sub-word alignment is carried by the mask.
REQ-011 SHALL commit a store on the edge entering RESP, writing only the byte lanes enabled in wmask; a store with wmask=0 writes nothing and completes normally.
REQ-012 SHALL register resp_rdata on the edge entering RESP: the stored word for loads, 0 for stores.
REQ-013 SHALL handle an out-of-range address as follows: no write, resp_rdata=0, resp_err=1, same latency as a normal access.
REQ-014 SHALL hold resp_valid, resp_rdata and resp_err stable in RESP until resp_ready=1.
REQ-015 SHALL, on the resp_valid&&resp_ready edge, return to IDLE and clear resp_valid and resp_err; req_ready rises in the next cycle, so back-to-back throughput is one transaction per LATENCY+2 cycles.
REQ-016 SHALL make a load issued after a completed store to the same word return the merged data.
REQ-017 SHALL ignore req_* inputs while not in IDLE.
REQ-018 SHALL treat address wrap as out of range: addr<BASE or addr-BASE>=8*DEPTH sets resp_err.

Reset
REQ-019 SHALL, while rst=1 at a clk edge: set state=IDLE, counter=0, resp_valid=0, resp_err=0, resp_rdata=0, req_ready=0 during the reset cycle, and req_ready=1 in the first cycle after rst deasserts.
REQ-020 SHALL abandon any transaction in WAIT or RESP when rst asserts; an uncommitted store is never written, and a store already committed in RESP remains.
REQ-021 SHALL not clear storage contents on reset.

Verification
REQ-022 Bench SHALL cover, with LATENCY=2:
- Store then load: store addr 0x8000_0010, wdata 0x1122334455667788, wmask 0xFF, then load the same address -> resp_valid 3 cycles after each accept; load returns 0x1122334455667788 with resp_err=0.
- Partial store: store wdata 0x00000000_AABB0000 with wmask 0x0C to 0x8000_0010, then load -> 0x11223344AABB7788.
- Out of range: load at 0x7FFF_FFF8, and a store at BASE+8*DEPTH -> resp_err=1, rdata=0; the following in-range load shows memory unchanged.
- Backpressure: resp_ready held 0 for 5 cycles -> resp_valid, rdata and err stable, req_ready=0 throughout; a new req_valid is not accepted.
- Reset mid-WAIT: accept a store to 0x8000_0020 with wdata 0xDEAD, assert rst in the next cycle -> resp_valid=0, req_ready=1 after reset; a load of 0x8000_0020 returns the old value.
- LATENCY=0 instance: load accepted at cycle t -> resp_valid at t+1; with resp_ready=1, req_ready=1 at t+2.
